// File: rtl/float_pkg.sv
// Shared binary32 types, constants and sequencer state encoding for the
// squared-multiply datapath stage.
package float_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  localparam int unsigned EXP_BIAS   = 127;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP_ONE     = 32'h3F80_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SQ,
    ST_MUL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/fp_mul.sv
// Combinational binary32 multiply, round-to-nearest-even, with subnormal
// inputs and outputs flushed to signed zero.
module fp_mul
  import float_pkg::*;
(
  input  fp32_t x,
  input  fp32_t y,
  output fp32_t z
);

  logic               x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, sgn;
  logic [47:0]        prod;
  logic               norm, g, r, st, rnd;
  logic [23:0]        mant;
  logic [24:0]        mant_r;
  logic [22:0]        frac;
  logic signed [9:0]  exp_s;

  assign x_zero = (x.exp == 8'd0);
  assign y_zero = (y.exp == 8'd0);
  assign x_inf  = (x.exp == 8'hFF) && (x.man == 23'd0);
  assign y_inf  = (y.exp == 8'hFF) && (y.man == 23'd0);
  assign x_nan  = (x.exp == 8'hFF) && (x.man != 23'd0);
  assign y_nan  = (y.exp == 8'hFF) && (y.man != 23'd0);
  assign sgn    = x.sign ^ y.sign;

  always_comb begin
    prod = 48'({1'b1, x.man}) * 48'({1'b1, y.man});
    norm = prod[47];
    if (norm) begin
      mant = prod[47:24];
      g    = prod[23];
      r    = prod[22];
      st   = |prod[21:0];
    end else begin
      mant = prod[46:23];
      g    = prod[22];
      r    = prod[21];
      st   = |prod[20:0];
    end
    // Ties go to even: round up on a half only when the kept lsb is odd.
    rnd    = g & (r | st | mant[0]);
    mant_r = {1'b0, mant} + 25'(rnd);
    frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    exp_s  = $signed({2'b00, x.exp}) + $signed({2'b00, y.exp})
           - $signed(10'(EXP_BIAS))
           + $signed({9'd0, norm}) + $signed({9'd0, mant_r[24]});
  end

  always_comb begin
    z = '0;
    if (x_nan || y_nan)
      z = fp32_t'(FP_QNAN);
    else if ((x_inf && y_zero) || (y_inf && x_zero))
      z = fp32_t'(FP_QNAN);
    else if (x_inf || y_inf)
      z = fp32_t'({sgn, FP_POS_INF[30:0]});
    else if (x_zero || y_zero)
      z = fp32_t'({sgn, 31'd0});
    else if (exp_s >= 10'sd255)
      z = fp32_t'({sgn, FP_POS_INF[30:0]});
    else if (exp_s <= 10'sd0)
      z = fp32_t'({sgn, 31'd0});
    else
      z = fp32_t'({sgn, exp_s[7:0], frac});
  end

endmodule

// File: rtl/float_sq_mul.sv
// (a*a)*b for the inverse-square-root pipeline: one shared multiplier used
// for the square and then the final product, start/ready handshake.
module float_sq_mul
  import float_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] float_in_sq,
  input  logic [31:0] float_in_mul,
  output logic [31:0] float_out,
  output logic        ready
);

  state_t state_q, state_d;
  fp32_t  a_reg, b_reg, sq_reg;
  fp32_t  mul_x, mul_y, mul_z;
  logic   accept;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin accept = 1'b1; state_d = ST_SQ; end
      ST_SQ:   state_d = ST_MUL;
      ST_MUL:  state_d = ST_DONE;
      ST_DONE: if (start) begin accept = 1'b1; state_d = ST_SQ; end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // The multiplier sees (a,a) while squaring and (a*a,b) afterwards.
  assign mul_x = (state_q == ST_MUL) ? sq_reg : a_reg;
  assign mul_y = (state_q == ST_MUL) ? b_reg  : a_reg;

  fp_mul u_fp_mul (
    .x (mul_x),
    .y (mul_y),
    .z (mul_z)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sq_reg    <= '0;
      float_out <= '0;
      ready     <= 1'b0;
    end else begin
      if (accept) begin
        a_reg <= fp32_t'(float_in_sq);
        b_reg <= fp32_t'(float_in_mul);
        ready <= 1'b0;
      end
      if (state_q == ST_SQ) sq_reg <= mul_z;
      if (state_q == ST_MUL) begin
        float_out <= mul_z;
        ready     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_float_sq_mul.sv
// Bench for float_sq_mul: directed table, random vectors against a
// real-arithmetic reference, and handshake/reset sequences.
module tb_float_sq_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] float_in_sq, float_in_mul;
  logic [31:0] float_out;
  logic        ready;

  int errors = 0;
  int checks = 0;

  float_sq_mul dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .float_in_sq  (float_in_sq),
    .float_in_mul (float_in_mul),
    .float_out    (float_out),
    .ready        (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Reference: operands widened to double (exact), products formed in real
  // arithmetic (exact for 24x24 bits), then rounded once to binary32 RNE.
  function automatic real to_real(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e11;
    e11 = 11'(int'(f[30:23]) - 127 + 1023);
    d   = {f[31], e11, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] to_f32(input real p);
    logic [63:0] d;
    logic [24:0] m;
    int          e;
    d = $realtobits(p);
    e = int'(d[62:52]) - 1023 + 127;
    m = {2'b01, d[51:29]};
    if (d[28] && ((|d[27:0]) || m[0])) m = m + 25'd1;
    if (m[24]) begin m = m >> 1; e = e + 1; end
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0)   return {d[63], 31'd0};
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] mul_ref(input logic [31:0] x, input logic [31:0] y);
    bit xn, yn, xi, yi, xz, yz, s;
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    xz = (x[30:23] == 8'h00);
    yz = (y[30:23] == 8'h00);
    s  = x[31] ^ y[31];
    if (xn || yn) return 32'h7FC00000;
    if ((xi && yz) || (yi && xz)) return 32'h7FC00000;
    if (xi || yi) return {s, 8'hFF, 23'd0};
    if (xz || yz) return {s, 31'd0};
    return to_f32(to_real(x) * to_real(y));
  endfunction

  function automatic logic [31:0] ref_sq_mul(input logic [31:0] a, input logic [31:0] b);
    return mul_ref(mul_ref(a, a), b);
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] sp [7];
    logic [7:0]  e;
    sp = '{32'h0, 32'h80000000, 32'h7F800000, 32'hFF800000,
           32'h7FC00000, 32'h00012345, 32'h7F812345};
    if ($urandom_range(0, 7) == 0) return sp[$urandom_range(0, 6)];
    e = 8'($urandom_range(100, 154));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // Issue one op; checks ready drops on the accepting edge, rises on the
  // third edge counting the accepting one, and the result.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input string nm);
    int cnt;
    @(negedge clk);
    start = 1'b1; float_in_sq = a; float_in_mul = b;
    @(posedge clk); #1;
    start = 1'b0; float_in_sq = $urandom; float_in_mul = $urandom;
    chk(ready == 1'b0, {nm, "_ready_fall"}, {31'd0, ready}, 32'd0);
    cnt = 1;
    while (!ready && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk(cnt == 3, {nm, "_latency"}, cnt, 32'd3);
    chk(float_out == expv, nm, float_out, expv);
  endtask

  initial begin
    vec_t        tbl [16];
    logic [31:0] a, b, ra, rb, held;
    int          hits;

    tbl = '{
      '{32'h40000000, 32'h40400000, 32'h41400000},
      '{32'hBFC00000, 32'h40000000, 32'h40900000},
      '{32'h3F800000, 32'hC0000000, 32'hC0000000},
      '{32'h3F800001, 32'h3F800000, 32'h3F800002},
      '{32'h00000000, 32'h7F800000, 32'h7FC00000},
      '{32'h60AD78EC, 32'h3F800000, 32'h7F800000},
      '{32'h1E3CE508, 32'h3F800000, 32'h00000000},
      '{32'h7FC00000, 32'h3F800000, 32'h7FC00000},
      '{32'h3F800000, 32'hFF800000, 32'hFF800000},
      '{32'hFF800000, 32'h3F800000, 32'h7F800000},
      '{32'h00400000, 32'h40000000, 32'h00000000},
      '{32'h00000000, 32'hC0000000, 32'h80000000},
      '{32'h5F800000, 32'h3F800000, 32'h7F800000},
      '{32'h1F800000, 32'h3F800000, 32'h00000000},
      '{32'h3F800000, 32'h00000001, 32'h00000000},
      '{32'h40000000, 32'hBF000000, 32'hC0000000}
    };

    rst = 1'b0; start = 1'b0; float_in_sq = '0; float_in_mul = '0;
    repeat (2) @(posedge clk);
    #1;
    chk(ready == 1'b0, "reset_ready", {31'd0, ready}, 32'd0);
    chk(float_out == 32'd0, "reset_out", float_out, 32'd0);
    @(negedge clk); rst = 1'b1;

    foreach (tbl[i]) do_op(tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("vec%0d", i));

    // Ignored start during SQ/MUL; result stays held in DONE afterwards.
    @(negedge clk);
    start = 1'b1; float_in_sq = 32'h40000000; float_in_mul = 32'h40400000;
    @(posedge clk); #1;
    float_in_sq = 32'h3F800000; float_in_mul = 32'h3F800000;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk(ready == 1'b1, "busy_start_ready", {31'd0, ready}, 32'd1);
    chk(float_out == 32'h41400000, "busy_start_out", float_out, 32'h41400000);
    repeat (3) @(posedge clk);
    #1;
    chk(ready == 1'b1 && float_out == 32'h41400000, "done_hold", float_out, 32'h41400000);

    // Start held high across the ready rise accepts the next op.
    @(negedge clk);
    start = 1'b1; float_in_sq = 32'hBFC00000; float_in_mul = 32'h40000000;
    @(posedge clk); #1;
    float_in_sq = 32'h40000000; float_in_mul = 32'h40400000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk(ready == 1'b1, "held_ready_rise", {31'd0, ready}, 32'd1);
    chk(float_out == 32'h40900000, "held_first_out", float_out, 32'h40900000);
    @(posedge clk); #1;
    start = 1'b0;
    chk(ready == 1'b0, "held_ready_fall", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk(ready == 1'b1 && float_out == 32'h41400000, "held_second_out", float_out, 32'h41400000);

    // Reset during MUL clears outputs at once; no ready without a new start.
    @(negedge clk);
    start = 1'b1; float_in_sq = 32'h3F800000; float_in_mul = 32'hC0000000;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk(ready == 1'b0, "midreset_ready", {31'd0, ready}, 32'd0);
    chk(float_out == 32'd0, "midreset_out", float_out, 32'd0);
    @(negedge clk); rst = 1'b1;
    hits = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready) hits++;
    end
    chk(hits == 0, "midreset_no_ready", hits, 32'd0);
    do_op(32'h40000000, 32'h40400000, 32'h41400000, "post_reset");

    // Back-to-back random operations against the reference.
    for (int i = 0; i < 2000; i++) begin
      ra = rand_op();
      rb = rand_op();
      a  = ra;
      b  = rb;
      held = ref_sq_mul(a, b);
      do_op(a, b, held, $sformatf("rnd%0d_%h_%h", i, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
